muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_div_iter.sv | 59 +++++
 rtl/muldiv_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_STEPS = 32;
    localparam int unsigned DIV_CNT_W = 5;

    // Quotient produced by the restoring algorithm for a zero divisor.
    localparam logic [XLEN-1:0] DIV0_QUO = 32'hFFFF_FFFF;

    // Controller states, kept as plain constants for legacy tooling.
    typedef logic [1:0] muldiv_state_t;
    localparam muldiv_state_t IDLE = 2'd0;
    localparam muldiv_state_t MUL  = 2'd1;
    localparam muldiv_state_t DIV  = 2'd2;
    localparam muldiv_state_t FIX  = 2'd3;

    // ALU operation codes shared with the core's control decoder.
    typedef enum logic [4:0] {
        ALU_OP_ADD   = 5'd0,
        ALU_OP_SUB   = 5'd1,
        ALU_OP_AND   = 5'd2,
        ALU_OP_OR    = 5'd3,
        ALU_OP_MULT  = 5'd16,
        ALU_OP_MULTU = 5'd17,
        ALU_OP_DIV   = 5'd18,
        ALU_OP_DIVU  = 5'd19
    } ctrl_alu_op_t;

    // Two's-complement magnitude of a word when treated as signed.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic is_signed);
        return (is_signed && x[XLEN-1]) ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// div_iter: 32-step restoring divider on unsigned magnitudes, one step per cycle.
module div_iter
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem,
    output logic            last_step
);

    logic [2*XLEN-1:0]  rq;
    logic [XLEN-1:0]    dvs;
    logic [DIV_CNT_W-1:0] cnt;
    logic               run;
    logic [XLEN:0]      diff;

    // Trial subtraction of the divisor from the shifted-in upper 33 bits.
    always_comb begin
        diff = rq[2*XLEN-1:XLEN-1] - {1'b0, dvs};
    end

    // Load operands on start, then iterate until the final step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq        <= '0;
            dvs       <= '0;
            cnt       <= '0;
            run       <= 1'b0;
            last_step <= 1'b0;
        end else if (kill) begin
            run       <= 1'b0;
            last_step <= 1'b0;
        end else if (start) begin
            rq        <= {XLEN'(0), a_mag};
            dvs       <= b_mag;
            cnt       <= '0;
            run       <= 1'b1;
            last_step <= 1'b0;
        end else if (run) begin
            if (diff[XLEN])
                rq <= {rq[2*XLEN-2:0], 1'b0};
            else
                rq <= {diff[XLEN-1:0], rq[XLEN-2:0], 1'b1};
            cnt       <= cnt + DIV_CNT_W'(1);
            last_step <= (cnt == DIV_CNT_W'(DIV_STEPS - 2));
            if (cnt == DIV_CNT_W'(DIV_STEPS - 1))
                run <= 1'b0;
        end
    end

    assign quo = rq[XLEN-1:0];
    assign rem = rq[2*XLEN-1:XLEN];

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner; sequences MULT/MULTU through a product pipe and
// DIV/DIVU through div_iter, plus MTHI/MTLO writes.
// Optional: MULDIV_DIV_EARLY_EN enables a 2-cycle divide for b==0 or |a|<|b|.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  ctrl_alu_op_t    req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            req_ready,
    input  logic            mt_we_hi,
    input  logic            mt_we_lo,
    input  logic [XLEN-1:0] mt_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned MCNT_W = 4;

    muldiv_state_t      state, state_nxt;
    logic               accept_mul, accept_div, commit_mul, commit_div, div_kill;
    logic               is_mul, is_div, sgn_mul, sgn_div;
    logic [2*XLEN-1:0]  ext_a, ext_b, product;
    logic [2*XLEN-1:0]  mul_pipe [MUL_LAT];
    logic [MCNT_W-1:0]  mul_cnt;
    logic [XLEN-1:0]    a_mag, b_mag, quo, rem, fix_hi, fix_lo;
    logic               neg_q, neg_r, b_zero, last_step, div_early;

    // Operand decode and sign handling for the incoming request.
    always_comb begin
        is_mul  = (req_op == ALU_OP_MULT) || (req_op == ALU_OP_MULTU);
        is_div  = (req_op == ALU_OP_DIV)  || (req_op == ALU_OP_DIVU);
        sgn_mul = (req_op == ALU_OP_MULT);
        sgn_div = (req_op == ALU_OP_DIV);
        ext_a   = sgn_mul ? {{XLEN{req_a[XLEN-1]}}, req_a} : {XLEN'(0), req_a};
        ext_b   = sgn_mul ? {{XLEN{req_b[XLEN-1]}}, req_b} : {XLEN'(0), req_b};
        product = ext_a * ext_b;
        a_mag   = mag(req_a, sgn_div);
        b_mag   = mag(req_b, sgn_div);
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_nxt  = state;
        accept_mul = 1'b0;
        accept_div = 1'b0;
        commit_mul = 1'b0;
        commit_div = 1'b0;
        div_kill   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && !flush) begin
                    if (is_mul) begin
                        accept_mul = 1'b1;
                        state_nxt  = MUL;
                    end else if (is_div) begin
                        accept_div = 1'b1;
                        state_nxt  = DIV;
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (mul_cnt == '0) begin
                    commit_mul = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            DIV: begin
                if (flush) begin
                    div_kill  = 1'b1;
                    state_nxt = IDLE;
                end else if (div_early) begin
                    div_kill  = 1'b1;
                    state_nxt = FIX;
                end else if (last_step) begin
                    state_nxt = FIX;
                end
            end
            default: begin
                if (!flush)
                    commit_div = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // State register plus registered handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            req_ready <= (state_nxt == IDLE);
            done      <= commit_mul || commit_div;
        end
    end

    // Product pipe and latency counter for multiplies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(MUL_LAT); i++) mul_pipe[i] <= '0;
            mul_cnt <= '0;
        end else begin
            if (accept_mul) mul_pipe[0] <= product;
            for (int i = 1; i < int'(MUL_LAT); i++) mul_pipe[i] <= mul_pipe[i-1];
            if (accept_mul)
                mul_cnt <= MCNT_W'(MUL_LAT - 1);
            else if (state == MUL && mul_cnt != '0)
                mul_cnt <= mul_cnt - MCNT_W'(1);
        end
    end

    // Sign flags captured at divide accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
        end else if (accept_div) begin
            neg_q  <= sgn_div && (req_a[XLEN-1] ^ req_b[XLEN-1]);
            neg_r  <= sgn_div && req_a[XLEN-1];
            b_zero <= (req_b == '0);
        end
    end

    div_iter u_div (
        .clk       (clk),
        .rst       (reset),
        .start     (accept_div),
        .kill      (div_kill),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .quo       (quo),
        .rem       (rem),
        .last_step (last_step)
    );

`ifdef MULDIV_DIV_EARLY_EN
    logic [XLEN-1:0] a_raw;

    // Early-exit flag and original dividend for the short divide path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_early <= 1'b0;
            a_raw     <= '0;
        end else if (accept_div) begin
            div_early <= (b_mag == '0) || (a_mag < b_mag);
            a_raw     <= req_a;
        end else if (state == FIX) begin
            div_early <= 1'b0;
        end
    end

    // Final sign fix-up; zero divisor keeps the all-ones quotient.
    always_comb begin
        if (div_early) begin
            fix_lo = b_zero ? DIV0_QUO : '0;
            fix_hi = a_raw;
        end else begin
            fix_lo = (neg_q && !b_zero) ? XLEN'(-quo) : quo;
            fix_hi = neg_r ? XLEN'(-rem) : rem;
        end
    end
`else
    assign div_early = 1'b0;

    // Final sign fix-up; zero divisor keeps the all-ones quotient.
    always_comb begin
        fix_lo = (neg_q && !b_zero) ? XLEN'(-quo) : quo;
        fix_hi = neg_r ? XLEN'(-rem) : rem;
    end
`endif

    // Architectural HI/LO: op commits, or MTHI/MTLO while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit_mul) begin
            {hi, lo} <= mul_pipe[MUL_LAT-1];
        end else if (commit_div) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end else if (state == IDLE) begin
            if (mt_we_hi) hi <= mt_data;
            if (mt_we_lo) lo <= mt_data;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (MUL_LAT = 3).
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EARLY_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 33;
`endif
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    ctrl_alu_op_t req_op = ALU_OP_ADD;
    logic [31:0]  req_a = '0;
    logic [31:0]  req_b = '0;
    logic         req_ready;
    logic         mt_we_hi = 1'b0;
    logic         mt_we_lo = 1'b0;
    logic [31:0]  mt_data = '0;
    logic         flush = 1'b0;
    logic         busy;
    logic         done;
    logic [31:0]  hi;
    logic [31:0]  lo;

    int total = 0;
    int bad   = 0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mt_we_hi  (mt_we_hi),
        .mt_we_lo  (mt_we_lo),
        .mt_data   (mt_data),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns #1 after the accepting edge.
    task automatic issue(input ctrl_alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        step();
        req_valid = 1'b0;
    endtask

    // Count edges until done; note whether req_ready rose while waiting.
    task automatic wait_done(output int n, output logic rdy_seen);
        n = 0;
        rdy_seen = 1'b0;
        while (done !== 1'b1 && n < 60) begin
            if (req_ready === 1'b1) rdy_seen = 1'b1;
            step();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input ctrl_alu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_lat);
        int   n;
        logic rdy_seen;
        issue(op, a, b);
        check1({tag, "_busy"}, busy, 1'b1);
        wait_done(n, rdy_seen);
        check32({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check1({tag, "_ready_low"}, rdy_seen, 1'b0);
        check32({tag, "_hi"}, hi, exp_hi);
        check32({tag, "_lo"}, lo, exp_lo);
        check1({tag, "_idle"}, busy, 1'b0);
        step();
        check1({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int   n;
        logic seen;

        // Reset state
        step();
        step();
        check32("rst_hi", hi, 32'h0);
        check32("rst_lo", lo, 32'h0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_ready", req_ready, 1'b1);
        reset = 1'b0;
        step();

        // Multiplies
        run_op("multu_ff", ALU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
        run_op("mult_neg", ALU_OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT);

        // Divides, including signed edge cases and divide by zero
        run_op("div_m7_2",   ALU_OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_op("div_min_m1", ALU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT);
        run_op("divu_by0",   ALU_OP_DIVU, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, EARLY_LAT);
        run_op("div_m7_by0", ALU_OP_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, EARLY_LAT);
        run_op("div_5_m9",   ALU_OP_DIV,  32'd5,         32'hFFFF_FFF7, 32'd5,         32'd0,         EARLY_LAT);
        run_op("div_m5_9",   ALU_OP_DIV,  32'hFFFF_FFFB, 32'd9,         32'hFFFF_FFFB, 32'd0,         EARLY_LAT);
        run_op("divu_100_7", ALU_OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT);

        // Flush a divide in flight at cycle 10
        issue(ALU_OP_DIVU, 32'd100, 32'd9);
        repeat (9) step();
        check1("flush_pre_busy", busy, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check1("flush_busy", busy, 1'b0);
        check1("flush_ready", req_ready, 1'b1);
        check1("flush_done", done, 1'b0);
        check32("flush_hi", hi, 32'd2);
        check32("flush_lo", lo, 32'd14);
        run_op("multu_6_7", ALU_OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen = 1'b1;
            step();
        end
        check1("flush_no_late_done", seen, 1'b0);
        check32("flush_late_lo", lo, 32'd42);

        // Flush in IDLE blocks a same-cycle request
        flush = 1'b1;
        issue(ALU_OP_MULTU, 32'd3, 32'd3);
        flush = 1'b0;
        check1("idle_flush_busy", busy, 1'b0);
        repeat (5) step();
        check32("idle_flush_lo", lo, 32'd42);

        // Unsupported opcode is not accepted
        issue(ALU_OP_ADD, 32'd1, 32'd2);
        check1("badop_busy", busy, 1'b0);
        check1("badop_ready", req_ready, 1'b1);

        // MTHI, then both strobes together
        mt_we_hi = 1'b1;
        mt_data  = 32'h0000_1234;
        step();
        mt_we_hi = 1'b0;
        check32("mthi_hi", hi, 32'h0000_1234);
        check32("mthi_lo", lo, 32'd42);
        mt_we_hi = 1'b1;
        mt_we_lo = 1'b1;
        mt_data  = 32'h0000_ABCD;
        step();
        mt_we_hi = 1'b0;
        mt_we_lo = 1'b0;
        check32("mtboth_hi", hi, 32'h0000_ABCD);
        check32("mtboth_lo", lo, 32'h0000_ABCD);

        // MTLO lands alongside an accepted op, then the op overwrites
        mt_we_lo = 1'b1;
        mt_data  = 32'h0000_0055;
        issue(ALU_OP_MULTU, 32'd2, 32'd3);
        mt_we_lo = 1'b0;
        check32("mt_same_lo", lo, 32'h0000_0055);
        check1("mt_same_busy", busy, 1'b1);
        wait_done(n, seen);
        check32("mt_same_lat", 32'(n), 32'(MUL_LAT));
        check32("mt_same_res_hi", hi, 32'd0);
        check32("mt_same_res_lo", lo, 32'd6);
        step();

        // Reset mid-divide
        issue(ALU_OP_DIVU, 32'd100, 32'd7);
        repeat (5) step();
        reset = 1'b1;
        #1;
        check32("rstmid_hi", hi, 32'd0);
        check32("rstmid_lo", lo, 32'd0);
        check1("rstmid_busy", busy, 1'b0);
        step();
        reset = 1'b0;
        step();
        check1("rstmid_ready", req_ready, 1'b1);
        check1("rstmid_done", done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
